// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronised RX, mid-bit sampling, parity/framing checks, sticky rdy with overrun.
// rdy rises CLK_DIV/2 + (DATA_BITS+parity+STOP_BITS)*CLK_DIV + 1 cycles after the detected start edge; clr_rdy acknowledges.
module uart_rx_param #(
    parameter int CLK_DIV   = 2604,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW   = $clog2(CLK_DIV);
    localparam int HALF = CLK_DIV / 2;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t                 state_q;
    logic                   sync1_q, sync2_q, prev_q;
    logic [CW-1:0]          cnt_q;
    logic [3:0]             bit_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   par_err_q, frm_err_q;
    logic [DATA_BITS-1:0]   rx_data_q;
    logic                   rdy_q, pe_q, fe_q, ov_q;

    logic rx_s, fall_d, tick_d, par_x_d, par_err_d, frm_err_d, ov_d;

    always_comb begin
        rx_s      = sync2_q;
        fall_d    = prev_q & ~rx_s;
        // START samples mid-bit; every later sample is one full bit period on
        tick_d    = (state_q == START) ? (cnt_q == CW'(HALF - 1)) : (cnt_q == CW'(CLK_DIV - 1));
        par_x_d   = (^shift_q) ^ rx_s;
        par_err_d = (PARITY == 1) ? ~par_x_d : par_x_d;
        frm_err_d = frm_err_q | ~rx_s;
        // an acknowledge coinciding with completion consumes the old word
        ov_d      = (clr_rdy && rdy_q) ? 1'b0 : (ov_q | rdy_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            prev_q    <= 1'b1;
            cnt_q     <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            pe_q      <= 1'b0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            sync1_q <= RX;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;

            if (clr_rdy && rdy_q) begin
                rdy_q <= 1'b0;
                pe_q  <= 1'b0;
                fe_q  <= 1'b0;
                ov_q  <= 1'b0;
            end

            if (state_q == IDLE || tick_d) cnt_q <= '0;
            else                           cnt_q <= cnt_q + CW'(1);

            case (state_q)
                IDLE: begin
                    if (fall_d) state_q <= START;
                end
                START: begin
                    if (tick_d) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            bit_q     <= '0;
                            par_err_q <= 1'b0;
                            frm_err_q <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (tick_d) begin
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == 4'(DATA_BITS - 1)) begin
                            bit_q   <= '0;
                            state_q <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                end
                PAR: begin
                    if (tick_d) begin
                        par_err_q <= par_err_d;
                        state_q   <= STOP;
                    end
                end
                STOP: begin
                    if (tick_d) begin
                        if (bit_q == 4'(STOP_BITS - 1)) begin
                            rx_data_q <= shift_q;
                            rdy_q     <= 1'b1;
                            pe_q      <= par_err_q;
                            fe_q      <= frm_err_d;
                            ov_q      <= ov_d;
                            bit_q     <= '0;
                            state_q   <= IDLE;
                        end else begin
                            frm_err_q <= frm_err_d;
                            bit_q     <= bit_q + 4'd1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data    = rx_data_q;
    assign rdy        = rdy_q;
    assign parity_err = pe_q;
    assign frame_err  = fe_q;
    assign overrun    = ov_q;

endmodule
